// File: rtl/frame_header_aligner.sv
// ---------------------------------------------------------------------------
// frame_header_aligner
//
// Word-alignment stage that sits in front of the descrambler. The serial
// deserializer delivers 32-bit words with an arbitrary bit phase. This block
// slides a 32-bit window across two consecutive words until it finds the 2-bit
// frame header, confirms the alignment, and then locks. While locked it hands
// the 30-bit scrambled payload to the descrambler, together with a per-frame
// enable that tells the descrambler whether the payload is scrambled.
//
// Ports
//   clock             in   1   rising-edge clock, shared with the deserializer
//   reset             in   1   asynchronous, active-high; clears all state
//   rawWord           in   32  unaligned deserializer word, bit 31 received first
//   rawValid          in   1   rawWord valid; all state advances only when 1
//   frameOut          out  30  aligned payload (window bits below the header)
//   frameValid        out  1   frameOut is a good-header frame taken while LOCKED
//   deScrambleEnable  out  1   frameValid and header == 2'b10
//   locked            out  1   state == LOCKED
//   bitOffset         out  5   current slip offset, 0..31
//
// Parameters
//   LOCK_COUNT     consecutive good headers needed to declare lock (2..255)
//   WINDOW         header-error monitoring window while locked, in words (2..255)
//   UNLOCK_ERRORS  bad headers within one window that force loss of lock
// ---------------------------------------------------------------------------
module frame_header_aligner #(
    parameter int LOCK_COUNT    = 64,
    parameter int WINDOW        = 64,
    parameter int UNLOCK_ERRORS = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] rawWord,
    input  logic        rawValid,
    output logic [29:0] frameOut,
    output logic        frameValid,
    output logic        deScrambleEnable,
    output logic        locked,
    output logic [4:0]  bitOffset
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } alignState_t;

    localparam logic [7:0] LOCK_TARGET  = 8'(LOCK_COUNT);
    localparam logic [7:0] WINDOW_LAST  = 8'(WINDOW - 1);
    localparam logic [7:0] UNLOCK_LIMIT = 8'(UNLOCK_ERRORS);

    alignState_t r_state;
    logic [31:0] r_prevWord;
    logic [4:0]  r_bitOffset;
    logic [7:0]  r_goodCnt;
    logic [7:0]  r_winCnt;
    logic [7:0]  r_errCnt;
    logic [29:0] r_frameOut;
    logic        r_frameValid;
    logic        r_deScrambleEnable;
    logic        r_locked;

    logic [63:0] w_window;
    logic [63:0] w_shifted;
    logic [31:0] w_aligned;
    logic [1:0]  w_hdr;
    logic [29:0] w_payload;
    logic        w_hdrOk;
    logic [7:0]  w_goodNext;
    logic [7:0]  w_errNew;

    // The previous word is the older half of the window, so an offset of zero
    // selects the previous word exactly and larger offsets pull bits in from
    // the current word. Shifting left by the offset and keeping the top half
    // gives window bits [63-offset -: 32] without a variable part-select.
    // A legal header is any pair of differing bits: 01 marks idle/control,
    // 10 marks a scrambled payload.
    assign w_window   = {r_prevWord, rawWord};
    assign w_shifted  = w_window << r_bitOffset;
    assign w_aligned  = w_shifted[63:32];
    assign w_hdr      = w_aligned[31:30];
    assign w_payload  = w_aligned[29:0];
    assign w_hdrOk    = (w_hdr == 2'b01) || (w_hdr == 2'b10);
    assign w_goodNext = r_goodCnt + 8'd1;
    assign w_errNew   = r_errCnt + {7'd0, ~w_hdrOk};

    // Alignment state machine and registered outputs. Nothing moves unless
    // rawValid is high, except that the per-frame strobes drop to zero on any
    // idle cycle so a stale frame is never presented twice. On a bad header
    // while hunting or verifying, the offset slips by one bit and the new
    // offset is applied to the next valid word; the 5-bit offset wraps from
    // 31 back to 0 on its own. Once locked, errors are counted within a
    // fixed window of accepted words and the counter restarts at each window
    // boundary; reaching the error limit drops lock even on the last word of
    // a window. Frames are only emitted for good headers seen while already
    // locked, so the word that completes verification and the word that
    // breaks lock are never forwarded. A bad header while locked leaves
    // frameOut holding its last payload.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state            <= HUNT;
            r_prevWord         <= 32'd0;
            r_bitOffset        <= 5'd0;
            r_goodCnt          <= 8'd0;
            r_winCnt           <= 8'd0;
            r_errCnt           <= 8'd0;
            r_frameOut         <= 30'd0;
            r_frameValid       <= 1'b0;
            r_deScrambleEnable <= 1'b0;
            r_locked           <= 1'b0;
        end else if (!rawValid) begin
            r_frameValid       <= 1'b0;
            r_deScrambleEnable <= 1'b0;
        end else begin
            r_prevWord         <= rawWord;
            r_frameValid       <= 1'b0;
            r_deScrambleEnable <= 1'b0;
            case (r_state)
                HUNT: begin
                    if (w_hdrOk) begin
                        r_state   <= VERIFY;
                        r_goodCnt <= 8'd1;
                    end else begin
                        r_bitOffset <= r_bitOffset + 5'd1;
                    end
                end
                VERIFY: begin
                    if (w_hdrOk) begin
                        r_goodCnt <= w_goodNext;
                        if (w_goodNext == LOCK_TARGET) begin
                            r_state  <= LOCKED;
                            r_locked <= 1'b1;
                            r_winCnt <= 8'd0;
                            r_errCnt <= 8'd0;
                        end
                    end else begin
                        r_state     <= HUNT;
                        r_goodCnt   <= 8'd0;
                        r_bitOffset <= r_bitOffset + 5'd1;
                    end
                end
                LOCKED: begin
                    if (w_errNew == UNLOCK_LIMIT) begin
                        r_state     <= HUNT;
                        r_locked    <= 1'b0;
                        r_bitOffset <= r_bitOffset + 5'd1;
                        r_goodCnt   <= 8'd0;
                        r_winCnt    <= 8'd0;
                        r_errCnt    <= 8'd0;
                    end else begin
                        if (r_winCnt == WINDOW_LAST) begin
                            r_winCnt <= 8'd0;
                            r_errCnt <= 8'd0;
                        end else begin
                            r_winCnt <= r_winCnt + 8'd1;
                            r_errCnt <= w_errNew;
                        end
                        if (w_hdrOk) begin
                            r_frameValid       <= 1'b1;
                            r_frameOut         <= w_payload;
                            r_deScrambleEnable <= (w_hdr == 2'b10);
                        end
                    end
                end
                default: begin
                    r_state  <= HUNT;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    assign frameOut         = r_frameOut;
    assign frameValid       = r_frameValid;
    assign deScrambleEnable = r_deScrambleEnable;
    assign locked           = r_locked;
    assign bitOffset        = r_bitOffset;

endmodule

// File: tb/tb_frame_header_aligner.sv
// ---------------------------------------------------------------------------
// tb_frame_header_aligner
//
// Self-checking bench for frame_header_aligner. A short table of hand-made
// words exercises the hunt/verify/slip decisions word by word. Longer runs
// build a serial bit stream of frames (header alternating 10/01) delayed by a
// chosen number of junk bits, cut it into 32-bit words, and check lock
// timing, slip offsets, payload bits and the error-window behaviour.
//
// Frames below index 40 use a payload that never contains a false header
// (10-frames carry all zeros, 01-frames all ones), so during the hunt only
// the true frame phase can match. With delay d, word j evaluated at offset
// j mod 32 matches first when j == d (d == 0 needs the 31->0 wrap, matching
// at word 32). From then on word j presents frame j-1.
// ---------------------------------------------------------------------------
module tb_frame_header_aligner;

    localparam int MAXW = 160;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] rawWord;
    logic        rawValid;
    logic [29:0] frameOut;
    logic        frameValid;
    logic        deScrambleEnable;
    logic        locked;
    logic [4:0]  bitOffset;

    int errors = 0;
    int checks = 0;

    bit badFrame [0:1023];

    logic        recLocked [0:MAXW-1];
    logic        recValid  [0:MAXW-1];
    logic        recDse    [0:MAXW-1];
    logic [29:0] recOut    [0:MAXW-1];
    logic [4:0]  recOff    [0:MAXW-1];

    typedef struct {
        logic        v;
        logic [31:0] w;
        logic [4:0]  expOff;
        logic        expLocked;
        logic        expValid;
    } vec_t;

    vec_t tbl [0:8];

    frame_header_aligner #(
        .LOCK_COUNT   (64),
        .WINDOW       (64),
        .UNLOCK_ERRORS(16)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .rawWord         (rawWord),
        .rawValid        (rawValid),
        .frameOut        (frameOut),
        .frameValid      (frameValid),
        .deScrambleEnable(deScrambleEnable),
        .locked          (locked),
        .bitOffset       (bitOffset)
    );

    // Free-running 100 MHz clock.
    always #5 clock = ~clock;

    // Safety net so the run always ends even if something stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [29:0] payloadAt(int k);
        logic [31:0] x;
        x = 32'(k + 1) * 32'h9E37_79B1;
        x = x ^ (x >> 13);
        return x[29:0];
    endfunction

    function automatic logic [31:0] frameAt(int k);
        logic [1:0]  h;
        logic [29:0] p;
        h = (k % 2 == 0) ? 2'b10 : 2'b01;
        if (k < 40) p = (h == 2'b10) ? 30'h0 : 30'h3FFF_FFFF;
        else        p = payloadAt(k);
        if (badFrame[k]) h = 2'b11;
        return {h, p};
    endfunction

    function automatic logic bitAt(int p, int d);
        int          q;
        logic [31:0] f;
        if (p < d) return 1'b1;
        q = p - d;
        f = frameAt(q / 32);
        return f[31 - (q % 32)];
    endfunction

    function automatic logic [31:0] rawAt(int j, int d);
        logic [31:0] w;
        for (int i = 0; i < 32; i++) w[31 - i] = bitAt(32 * j + i, d);
        return w;
    endfunction

    function automatic logic [29:0] expPayload(int k);
        logic [31:0] f;
        f = frameAt(k);
        return f[29:0];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] w);
        rawValid = v;
        rawWord  = w;
        @(posedge clock);
        #1;
    endtask

    task automatic doReset();
        reset    = 1'b1;
        rawValid = 1'b0;
        rawWord  = 32'd0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic clearBad();
        for (int k = 0; k < 1024; k++) badFrame[k] = 1'b0;
    endtask

    // Resets the DUT, streams nWords words of the delayed frame stream and
    // records the outputs after each valid word. With gap > 0, idle cycles
    // carrying random garbage follow every word and the first idle cycle is
    // checked for cleared strobes and held state.
    task automatic runStream(input int d, input int nWords, input int gap);
        doReset();
        for (int j = 0; j < nWords; j++) begin
            applyStimulus(1'b1, rawAt(j, d));
            recLocked[j] = locked;
            recValid[j]  = frameValid;
            recDse[j]    = deScrambleEnable;
            recOut[j]    = frameOut;
            recOff[j]    = bitOffset;
            for (int g = 0; g < gap; g++) begin
                applyStimulus(1'b0, $urandom);
                if (g == 0) begin
                    checkOutput($sformatf("idle valid w%0d", j), frameValid, 0);
                    checkOutput($sformatf("idle dse w%0d", j), deScrambleEnable, 0);
                    checkOutput($sformatf("idle out w%0d", j), frameOut, recOut[j]);
                    checkOutput($sformatf("idle lock w%0d", j), locked, recLocked[j]);
                    checkOutput($sformatf("idle off w%0d", j), bitOffset, recOff[j]);
                end
            end
        end
        rawValid = 1'b0;
    endtask

    initial begin
        // Word-by-word hunt/verify table starting from reset.
        tbl[0] = '{1'b1, 32'h0000_0000, 5'd1, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 32'h4000_0000, 5'd1, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 32'h1000_0000, 5'd2, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 32'h2000_0000, 5'd2, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 32'h3000_0000, 5'd2, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 32'h0000_0000, 5'd2, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 32'h0800_0000, 5'd3, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 32'h0000_0000, 5'd3, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 32'h0000_0000, 5'd4, 1'b0, 1'b0};

        clearBad();
        doReset();
        checkOutput("reset frameOut", frameOut, 0);
        checkOutput("reset frameValid", frameValid, 0);
        checkOutput("reset dse", deScrambleEnable, 0);
        checkOutput("reset locked", locked, 0);
        checkOutput("reset bitOffset", bitOffset, 0);

        for (int i = 0; i < 9; i++) begin
            applyStimulus(tbl[i].v, tbl[i].w);
            checkOutput($sformatf("tbl%0d offset", i), bitOffset, tbl[i].expOff);
            checkOutput($sformatf("tbl%0d locked", i), locked, tbl[i].expLocked);
            checkOutput($sformatf("tbl%0d valid", i), frameValid, tbl[i].expValid);
        end

        // Aligned stream: hunt wraps 31->0, verify from word 32, lock on word 95.
        runStream(0, 110, 0);
        checkOutput("d0 off w30", recOff[30], 31);
        checkOutput("d0 off w31", recOff[31], 0);
        checkOutput("d0 lock w94", recLocked[94], 0);
        checkOutput("d0 lock w95", recLocked[95], 1);
        checkOutput("d0 valid w95", recValid[95], 0);
        checkOutput("d0 off w95", recOff[95], 0);
        for (int j = 96; j < 110; j++) begin
            checkOutput($sformatf("d0 valid w%0d", j), recValid[j], 1);
            checkOutput($sformatf("d0 out w%0d", j), recOut[j], expPayload(j - 1));
            checkOutput($sformatf("d0 dse w%0d", j), recDse[j], ((j - 1) % 2 == 0) ? 1 : 0);
        end

        // Five-bit delay: five slips, verify from word 5, lock on word 68.
        runStream(5, 90, 0);
        checkOutput("d5 off w3", recOff[3], 4);
        checkOutput("d5 off w4", recOff[4], 5);
        checkOutput("d5 off w5", recOff[5], 5);
        checkOutput("d5 lock w67", recLocked[67], 0);
        checkOutput("d5 lock w68", recLocked[68], 1);
        checkOutput("d5 valid w68", recValid[68], 0);
        checkOutput("d5 valid w69", recValid[69], 1);
        checkOutput("d5 out w69", recOut[69], expPayload(68));
        checkOutput("d5 dse w69", recDse[69], 1);
        checkOutput("d5 dse w70", recDse[70], 0);
        checkOutput("d5 valid w89", recValid[89], 1);

        // Reset in the middle of lock clears outputs without waiting for a clock.
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async rst locked", locked, 0);
        checkOutput("async rst valid", frameValid, 0);
        checkOutput("async rst dse", deScrambleEnable, 0);
        checkOutput("async rst out", frameOut, 0);
        checkOutput("async rst off", bitOffset, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        applyStimulus(1'b1, rawAt(0, 5));
        checkOutput("post rst off", bitOffset, 1);
        checkOutput("post rst locked", locked, 0);
        rawValid = 1'b0;

        // 31-bit delay: match at offset 31 on word 31 without wrapping.
        runStream(31, 100, 0);
        checkOutput("d31 off w29", recOff[29], 30);
        checkOutput("d31 off w30", recOff[30], 31);
        checkOutput("d31 off w31", recOff[31], 31);
        checkOutput("d31 lock w93", recLocked[93], 0);
        checkOutput("d31 lock w94", recLocked[94], 1);
        checkOutput("d31 off w94", recOff[94], 31);
        checkOutput("d31 out w95", recOut[95], expPayload(94));

        // Fifteen bad headers in one window: lock held, only those words dropped.
        clearBad();
        for (int k = 70; k <= 98; k += 2) badFrame[k] = 1'b1;
        runStream(5, 140, 0);
        for (int j = 69; j < 140; j++) begin
            checkOutput($sformatf("e15 lock w%0d", j), recLocked[j], 1);
            checkOutput($sformatf("e15 valid w%0d", j), recValid[j], badFrame[j - 1] ? 0 : 1);
            if (badFrame[j - 1])
                checkOutput($sformatf("e15 hold w%0d", j), recOut[j], expPayload(j - 2));
        end
        checkOutput("e15 off", recOff[139], 5);

        // Sixteen bad headers: lock falls on the sixteenth, offset slips.
        clearBad();
        for (int k = 70; k <= 100; k += 2) badFrame[k] = 1'b1;
        runStream(5, 110, 0);
        checkOutput("e16 valid w99", recValid[99], 0);
        checkOutput("e16 valid w100", recValid[100], 1);
        checkOutput("e16 lock w100", recLocked[100], 1);
        checkOutput("e16 off w100", recOff[100], 5);
        checkOutput("e16 lock w101", recLocked[101], 0);
        checkOutput("e16 valid w101", recValid[101], 0);
        checkOutput("e16 off w101", recOff[101], 6);

        // Ten errors either side of a window boundary: counter restarts, lock held.
        clearBad();
        for (int k = 121; k <= 130; k++) badFrame[k] = 1'b1;
        for (int k = 132; k <= 141; k++) badFrame[k] = 1'b1;
        runStream(5, 150, 0);
        for (int j = 122; j < 150; j++)
            checkOutput($sformatf("bnd lock w%0d", j), recLocked[j], 1);
        checkOutput("bnd valid w132", recValid[132], 1);
        checkOutput("bnd valid w133", recValid[133], 0);
        checkOutput("bnd off", recOff[149], 5);

        // Bad header when verify is one word from lock: back to hunt, no frames.
        clearBad();
        badFrame[67] = 1'b1;
        runStream(5, 85, 0);
        checkOutput("vab off w67", recOff[67], 5);
        checkOutput("vab off w68", recOff[68], 6);
        for (int j = 60; j < 85; j++) begin
            checkOutput($sformatf("vab lock w%0d", j), recLocked[j], 0);
            checkOutput($sformatf("vab valid w%0d", j), recValid[j], 0);
        end

        // rawValid one cycle in three: same lock timing in valid words.
        clearBad();
        runStream(5, 90, 2);
        checkOutput("gate off w4", recOff[4], 5);
        checkOutput("gate lock w67", recLocked[67], 0);
        checkOutput("gate lock w68", recLocked[68], 1);
        checkOutput("gate valid w69", recValid[69], 1);
        checkOutput("gate out w69", recOut[69], expPayload(68));
        checkOutput("gate out w80", recOut[80], expPayload(79));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
